// File: rtl/shift_crc_ctrl_if.sv
// Handshake bundle for shift_crc_ctrl: parallel word in, CRC result out.
// The producer/consumer side uses modport master; the sequencer uses slave.
interface shift_crc_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int CRC_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              crc_valid;
    logic              crc_ready;
    logic [CRC_W-1:0]  crc_out;

    modport master (
        output in_valid,
        output in_data,
        output crc_ready,
        input  in_ready,
        input  crc_valid,
        input  crc_out
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  crc_ready,
        output in_ready,
        output crc_valid,
        output crc_out
    );
endinterface

// File: rtl/shift_crc_ctrl.sv
// Serializes a parallel word MSB-first into a CRC-4 LFSR and a serial port,
// then offers the CRC on a handshake. Define CRC_XOR_OUT_EN to invert crc_out.
module shift_crc_ctrl #(
    parameter int               DATA_W   = 8,
    parameter int               CRC_W    = 4,
    parameter logic [CRC_W-1:0] POLY     = 4'b0011,
    parameter logic [CRC_W-1:0] CRC_INIT = 4'b0000,
    localparam int              CNT_W    = $clog2(DATA_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    shift_crc_ctrl_if.slave  bus,
    input  logic             clear,
    output logic             sr_din,
    output logic             sr_shift,
    output logic             busy,
    output logic [CNT_W-1:0] bit_cnt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    logic [1:0]        state_q,   state_d;
    logic [DATA_W-1:0] hold_q,    hold_d;
    logic [CRC_W-1:0]  crc_q,     crc_d;
    logic [CRC_W-1:0]  crc_out_q, crc_out_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;

    logic              ser_bit;
    logic              fb;
    logic [CRC_W-1:0]  crc_step;
    logic [CRC_W-1:0]  xor_mask;

`ifdef CRC_XOR_OUT_EN
    assign xor_mask = '1;
`else
    assign xor_mask = '0;
`endif

    // One LFSR step with the bit currently at the top of the hold register.
    assign ser_bit  = hold_q[DATA_W-1];
    assign fb       = crc_q[CRC_W-1] ^ ser_bit;
    assign crc_step = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        crc_d     = crc_q;
        crc_out_d = crc_out_q;
        cnt_d     = cnt_q;

        if (clear) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        hold_d  = bus.in_data;
                        crc_d   = CRC_INIT;
                        cnt_d   = '0;
                        state_d = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    hold_d = hold_q << 1;
                    crc_d  = crc_step;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d   = ST_DONE;
                        crc_out_d = crc_step ^ xor_mask;
                    end
                end
                ST_DONE: begin
                    if (bus.crc_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            hold_q    <= '0;
            crc_q     <= CRC_INIT;
            crc_out_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            crc_q     <= crc_d;
            crc_out_q <= crc_out_d;
            cnt_q     <= cnt_d;
        end
    end

    // Outputs decode directly from state so reset clears them immediately.
    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.crc_valid = (state_q == ST_DONE);
    assign bus.crc_out   = crc_out_q;
    assign sr_shift      = (state_q == ST_SHIFT);
    assign sr_din        = (state_q == ST_SHIFT) & ser_bit;
    assign busy          = (state_q != ST_IDLE);
    assign bit_cnt       = cnt_q;

endmodule

// File: tb/tb_shift_crc_ctrl.sv
// Self-checking bench for shift_crc_ctrl: cycle-level model plus directed
// vectors with hand-computed CRCs (0x01 -> 0x3, 0xFF -> 0x4 before output XOR).
module tb_shift_crc_ctrl;

    localparam int DATA_W = 8;
    localparam int CNT_W  = $clog2(DATA_W + 1);
`ifdef CRC_XOR_OUT_EN
    localparam logic [3:0] XOR_OUT = 4'hF;
`else
    localparam logic [3:0] XOR_OUT = 4'h0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clear;
    logic             sr_din;
    logic             sr_shift;
    logic             busy;
    logic [CNT_W-1:0] bit_cnt;

    shift_crc_ctrl_if #(.DATA_W(DATA_W), .CRC_W(4)) bus ();

    shift_crc_ctrl #(
        .DATA_W  (DATA_W),
        .CRC_W   (4),
        .POLY    (4'b0011),
        .CRC_INIT(4'b0000)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .clear   (clear),
        .sr_din  (sr_din),
        .sr_shift(sr_shift),
        .busy    (busy),
        .bit_cnt (bit_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // CRC as polynomial remainder: (word * x^4) mod (x^4 + x + 1).
    function automatic logic [3:0] ref_crc(input logic [DATA_W-1:0] w);
        logic [DATA_W+3:0] r;
        logic [DATA_W+3:0] g;
        r = {w, 4'b0000};
        g = {{(DATA_W-1){1'b0}}, 5'b10011};
        for (int i = DATA_W + 3; i >= 4; i--) begin
            if (r[i]) r = r ^ (g << (i - 4));
        end
        return r[3:0];
    endfunction

    // Model: m_k = -1 idle, 0..DATA_W-1 serializing bit m_k, DATA_W result offered.
    int               m_k;
    int               m_idle_cnt;
    logic [DATA_W-1:0] m_word;
    logic [3:0]       m_crc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_k        <= -1;
            m_idle_cnt <= 0;
            m_crc      <= 4'h0;
        end else if (clear) begin
            m_k        <= -1;
            m_idle_cnt <= 0;
        end else if (m_k < 0) begin
            if (bus.in_valid) begin
                m_word <= bus.in_data;
                m_k    <= 0;
            end
        end else if (m_k < DATA_W) begin
            m_k <= m_k + 1;
            if (m_k == DATA_W - 1) m_crc <= ref_crc(m_word) ^ XOR_OUT;
        end else if (bus.crc_ready) begin
            m_k        <= -1;
            m_idle_cnt <= DATA_W;
        end
    end

    int               cyc = 0;
    int               s_cyc;
    logic             s_valid, s_in_ready, s_busy;
    logic [3:0]       s_crc;
    logic [CNT_W-1:0] s_cnt;
    logic [63:0]      stream;
    int               nbits, n_acc, last_acc, prev_acc;

    // One clock: compare everything at the falling edge, then advance past the rising edge.
    task automatic tick();
        logic will_acc;
        logic e_ir, e_busy, e_sh, e_din, e_cv;
        int   e_cnt;
        @(negedge clk);
        s_cyc      = cyc;
        s_valid    = bus.crc_valid;
        s_in_ready = bus.in_ready;
        s_busy     = busy;
        s_crc      = bus.crc_out;
        s_cnt      = bit_cnt;
        if (m_k < 0) begin
            e_ir = 1; e_busy = 0; e_sh = 0; e_din = 0; e_cv = 0; e_cnt = m_idle_cnt;
        end else if (m_k < DATA_W) begin
            e_ir = 0; e_busy = 1; e_sh = 1; e_din = m_word[DATA_W-1-m_k]; e_cv = 0; e_cnt = m_k;
        end else begin
            e_ir = 0; e_busy = 1; e_sh = 0; e_din = 0; e_cv = 1; e_cnt = DATA_W;
        end
        chk("cyc_in_ready",  32'(bus.in_ready),  32'(e_ir));
        chk("cyc_busy",      32'(busy),          32'(e_busy));
        chk("cyc_sr_shift",  32'(sr_shift),      32'(e_sh));
        chk("cyc_sr_din",    32'(sr_din),        32'(e_din));
        chk("cyc_crc_valid", 32'(bus.crc_valid), 32'(e_cv));
        chk("cyc_bit_cnt",   32'(bit_cnt),       32'(e_cnt));
        chk("cyc_crc_out",   32'(bus.crc_out),   32'(m_crc));
        if (sr_shift === 1'b1) begin
            stream = {stream[62:0], sr_din};
            nbits++;
        end
        will_acc = rst_n && s_in_ready && bus.in_valid && !clear;
        @(posedge clk);
        cyc++;
        if (will_acc) begin
            prev_acc = last_acc;
            last_acc = cyc;
            n_acc++;
        end
        #1;
    endtask

    task automatic wait_acc(input int target, input string name);
        int i;
        i = 0;
        while (n_acc < target && i < 30) begin
            tick();
            i++;
        end
        if (n_acc < target) begin
            n_tests++; n_fail++;
            $display("FAIL %s_accept_timeout: got no accept expected accept", name);
        end
    endtask

    task automatic send(input logic [DATA_W-1:0] w, input string name);
        int a;
        a = n_acc;
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        wait_acc(a + 1, name);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int i;
        i = 0;
        do begin
            tick();
            i++;
        end while (s_valid !== 1'b1 && i < 40);
        if (s_valid !== 1'b1) begin
            n_tests++; n_fail++;
            $display("FAIL %s_valid_timeout: got crc_valid=0 expected crc_valid=1", name);
        end
    endtask

    initial begin
        int nb0, nv, a, i;
        rst_n = 1'b0;
        clear = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.crc_ready = 1'b0;
        stream = '0; nbits = 0; n_acc = 0; last_acc = 0; prev_acc = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // 1: asynchronous reset in the middle of serializing 0xA5
        bus.crc_ready = 1'b1;
        send(8'hA5, "t1");
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("t1_in_ready",  32'(bus.in_ready),  32'd1);
        chk("t1_busy",      32'(busy),          32'd0);
        chk("t1_sr_shift",  32'(sr_shift),      32'd0);
        chk("t1_crc_valid", 32'(bus.crc_valid), 32'd0);
        chk("t1_bit_cnt",   32'(bit_cnt),       32'd0);
        chk("t1_crc_out",   32'(bus.crc_out),   32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // 2: word 0x01, consumer always ready
        nb0 = nbits;
        send(8'h01, "t2");
        wait_valid("t2");
        chk("t2_crc",     32'(s_crc),           32'(4'h3 ^ XOR_OUT));
        chk("t2_nbits",   32'(nbits - nb0),     32'd8);
        chk("t2_stream",  32'(stream[7:0]),     32'h01);
        // crc_valid appears in the (DATA_W+1)th cycle, DATA_W edges after the accept edge
        chk("t2_latency", 32'(s_cyc - last_acc), 32'(DATA_W));
        tick();
        chk("t2_valid_one_cycle", 32'(s_valid), 32'd0);

        // 3: word 0xFF with a stalled consumer
        bus.crc_ready = 1'b0;
        send(8'hFF, "t3");
        wait_valid("t3");
        chk("t3_crc", 32'(s_crc), 32'(4'h4 ^ XOR_OUT));
        repeat (5) begin
            tick();
            chk("t3_hold_crc",   32'(s_crc),      32'(4'h4 ^ XOR_OUT));
            chk("t3_hold_valid", 32'(s_valid),    32'd1);
            chk("t3_hold_ready", 32'(s_in_ready), 32'd0);
        end
        bus.crc_ready = 1'b1;
        tick();
        tick();
        chk("t3_idle_ready", 32'(s_in_ready), 32'd1);
        chk("t3_idle_valid", 32'(s_valid),    32'd0);

        // 4: back-to-back words with in_valid held high
        a = n_acc;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h01;
        wait_acc(a + 1, "t4a");
        bus.in_data  = 8'hFF;
        wait_valid("t4a");
        chk("t4_crc0", 32'(s_crc), 32'(4'h3 ^ XOR_OUT));
        wait_acc(a + 2, "t4b");
        bus.in_valid = 1'b0;
        chk("t4_period", 32'(last_acc - prev_acc), 32'(DATA_W + 2));
        wait_valid("t4b");
        chk("t4_crc1", 32'(s_crc), 32'(4'h4 ^ XOR_OUT));
        tick();

        // 5: clear at bit_cnt=4 with a competing in_valid
        send(8'hFF, "t5");
        i = 0;
        while (bit_cnt !== CNT_W'(4) && i < 20) begin
            tick();
            i++;
        end
        clear        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        tick();
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        chk("t5_busy",     32'(s_busy),     32'd0);
        chk("t5_in_ready", 32'(s_in_ready), 32'd1);
        chk("t5_bit_cnt",  32'(s_cnt),      32'd0);
        nv = 0;
        repeat (12) begin
            tick();
            if (s_valid === 1'b1) nv++;
        end
        chk("t5_no_valid", 32'(nv), 32'd0);
        send(8'h01, "t5b");
        wait_valid("t5b");
        chk("t5_crc_after", 32'(s_crc), 32'(4'h3 ^ XOR_OUT));
        tick();

        // 6: in_data scrambled while serializing 0x01
        a = n_acc;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h01;
        wait_acc(a + 1, "t6");
        bus.in_valid = 1'b0;
        nb0 = nbits;
        repeat (DATA_W) begin
            bus.in_data = 8'($urandom);
            tick();
        end
        wait_valid("t6");
        chk("t6_crc",    32'(s_crc),       32'(4'h3 ^ XOR_OUT));
        chk("t6_nbits",  32'(nbits - nb0), 32'd8);
        chk("t6_stream", 32'(stream[7:0]), 32'h01);
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
